// File: rtl/apple_generator.sv
// -----------------------------------------------------------------------------
// apple_generator
//
// Holds the apple cell for the 16x16 snake grid. It also tells the display
// path whether the cell currently being drawn is the apple.
//
// When the snake eats the apple (goodColl), the apple moves to the random
// candidate cell (randX, randY). A candidate that lands on a live body segment
// is rejected. The request then stays pending, and the block tries the fresh
// random candidate on every following cycle until one is free.
//
// Optional build macro:
//   APPLE_BORDER_REJECT_EN - also reject candidates on the wall ring
//                            (column or row equal to 0 or 15).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   s_reset  - synchronous active-high soft reset (new game)
//   x, y     - cell currently being drawn
//   randX    - random candidate column
//   randY    - random candidate row
//   goodColl - head hit the apple; request relocation
//   body     - NUM_SEG segment bytes {X[7:4], Y[3:0]}; 8'h00 = unused slot
//   apple    - registered; 1 when (x,y) matched the apple cell
// -----------------------------------------------------------------------------
module apple_generator #(
  parameter int         NUM_SEG = 50,
  parameter logic [3:0] INIT_X  = 4'd10,
  parameter logic [3:0] INIT_Y  = 4'd7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_reset,
  input  logic [3:0]              x,
  input  logic [3:0]              y,
  input  logic [3:0]              randX,
  input  logic [3:0]              randY,
  input  logic                    goodColl,
  input  logic [NUM_SEG-1:0][7:0] body,
  output logic                    apple
);

  logic [3:0] apple_x;
  logic [3:0] apple_y;
  logic       pend;
  logic       occ;
  logic       req;

  // A candidate is occupied when it matches any used body slot. All slots are
  // compared in parallel. A zero byte marks an empty slot, so an empty slot
  // never blocks cell (0,0).
  always_comb begin
    // NOTE: assign a default before the loop so that no path leaves occ unassigned; that would infer a latch.
    occ = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (body[i] != 8'h00 && body[i] == {randX, randY}) occ = 1'b1;
    end
`ifdef APPLE_BORDER_REJECT_EN
    if (randX == 4'd0 || randX == 4'd15 || randY == 4'd0 || randY == 4'd15)
      occ = 1'b1;
`endif
  end

  // A rejected request stays alive through pend until a free candidate appears.
  assign req = goodColl | pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      apple_x <= INIT_X;
      apple_y <= INIT_Y;
      pend    <= 1'b0;
      apple   <= 1'b0;
    end else if (s_reset) begin
      apple_x <= INIT_X;
      apple_y <= INIT_Y;
      pend    <= 1'b0;
      apple   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the compare below see the position from before this edge, so a move shows on apple one clock later.
      apple <= (x == apple_x) && (y == apple_y);
      if (req) begin
        if (!occ) begin
          apple_x <= randX;
          apple_y <= randY;
          pend    <= 1'b0;
        end else begin
          pend    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apple_generator.sv
// -----------------------------------------------------------------------------
// tb_apple_generator
//
// Directed scenarios followed by a randomized run. Both are compared against
// a behavioural model of the apple position, the pending request and the
// registered apple output.
// -----------------------------------------------------------------------------
module tb_apple_generator;

  localparam int NUM_SEG = 50;

  logic                    tb_clk;
  logic                    reset;
  logic                    s_reset;
  logic [3:0]              x;
  logic [3:0]              y;
  logic [3:0]              randX;
  logic [3:0]              randY;
  logic                    goodColl;
  logic [NUM_SEG-1:0][7:0] body;
  logic                    apple;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_x;
  int m_y;
  bit m_pend;
  bit m_apple;

  apple_generator #(
    .NUM_SEG(NUM_SEG),
    .INIT_X (4'd10),
    .INIT_Y (4'd7)
  ) dut (
    .clk     (tb_clk),
    .reset   (reset),
    .s_reset (s_reset),
    .x       (x),
    .y       (y),
    .randX   (randX),
    .randY   (randY),
    .goodColl(goodColl),
    .body    (body),
    .apple   (apple)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Build an occupancy map of the grid from the snake body, then look the
  // candidate up in it.
  function automatic bit model_occupied(input int rx, input int ry);
    bit grid [16][16];
    bit border;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (body[i] != 8'h00) grid[body[i][7:4]][body[i][3:0]] = 1'b1;
    end
    border = 1'b0;
`ifdef APPLE_BORDER_REJECT_EN
    border = (rx == 0) || (rx == 15) || (ry == 0) || (ry == 15);
`endif
    return grid[rx][ry] || border;
  endfunction

  task automatic model_reset();
    m_x     = 10;
    m_y     = 7;
    m_pend  = 1'b0;
    m_apple = 1'b0;
  endtask

  // Model one rising edge, using the inputs that are held across it.
  task automatic model_edge();
    if (s_reset) begin
      model_reset();
    end else begin
      m_apple = (int'(x) == m_x) && (int'(y) == m_y);
      if (goodColl || m_pend) begin
        if (!model_occupied(int'(randX), int'(randY))) begin
          m_x    = int'(randX);
          m_y    = int'(randY);
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, update the model and compare the output after the edge.
  task automatic step(input string tag);
    @(posedge tb_clk);
    model_edge();
    #1;
    check(tag, apple, m_apple);
  endtask

  initial begin
    reset    = 1'b1;
    s_reset  = 1'b0;
    x        = 4'd1;
    y        = 4'd1;
    randX    = 4'd0;
    randY    = 4'd0;
    goodColl = 1'b0;
    body     = '0;
    model_reset();

    // Power-on reset held for two edges
    repeat (2) begin
      @(posedge tb_clk);
      #1;
      check("por_apple", apple, 1'b0);
    end
    reset = 1'b0;
    x = 4'd10; y = 4'd7;
    step("init_pos_hit");
    check("init_pos_const", apple, 1'b1);

    // Relocate to a free cell (5,8)
    body[0] = 8'h48; body[1] = 8'h47; body[2] = 8'h46; body[3] = 8'h45;
    randX = 4'd5; randY = 8'd8; x = 4'd5; y = 4'd8; goodColl = 1'b1;
    step("reloc_edge1");
    check("reloc_edge1_const", apple, 1'b0);
    goodColl = 1'b0;
    step("reloc_edge2");
    check("reloc_edge2_const", apple, 1'b1);

    // Soft reset returns the apple to (10,7)
    s_reset = 1'b1; x = 4'd10; y = 4'd7;
    step("sreset_edge");
    s_reset = 1'b0;
    step("sreset_init_hit");
    check("sreset_init_const", apple, 1'b1);
    x = 4'd5; y = 4'd8;
    step("sreset_old_miss");

    // Rejection: candidate (4,8) sits on the body
    randX = 4'd4; randY = 4'd8; x = 4'd4; y = 4'd8; goodColl = 1'b1;
    step("reject_edge");
    check("reject_const", apple, 1'b0);
    // Retry through pend: position still 10,7 before this edge
    goodColl = 1'b0; randX = 4'd9; randY = 4'd2; x = 4'd10; y = 4'd7;
    step("reject_held_pos");
    check("reject_held_const", apple, 1'b1);
    x = 4'd9; y = 4'd2;
    step("retry_accepted");
    check("retry_accepted_const", apple, 1'b1);

    // Border candidate (0,3): rejected only in the border-reject build
    randX = 4'd0; randY = 4'd3; goodColl = 1'b1; x = 4'd0; y = 4'd3;
    step("border_edge");
    goodColl = 1'b0; randX = 4'd4; randY = 4'd7;   // occupied, so a pending retry fails
    step("border_result");
`ifdef APPLE_BORDER_REJECT_EN
    check("border_rejected", apple, 1'b0);
`else
    check("border_accepted", apple, 1'b1);
`endif

    // Asynchronous reset in the middle of a pending relocation
    randX = 4'd4; randY = 4'd6; goodColl = 1'b1;
    step("pend_setup");
    goodColl = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_apple", apple, 1'b0);
    @(posedge tb_clk);
    #1;
    reset = 1'b0;
    randX = 4'd3; randY = 4'd3; x = 4'd3; y = 4'd3;   // free, but pend must be cleared
    step("reset_cleared_pend");
    step("reset_no_move");
    check("reset_no_move_const", apple, 1'b0);

    // Randomized run
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < 8; i++)
          body[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 9) < 4) begin
        {randX, randY} = body[$urandom_range(0, 7)];
      end else begin
        randX = 4'($urandom); randY = 4'($urandom);
      end
      goodColl = ($urandom_range(0, 3) == 0);
      s_reset  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) begin
        x = 4'(m_x); y = 4'(m_y);
      end else begin
        x = 4'($urandom); y = 4'($urandom);
      end
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apple_generator.md
Name: apple_generator

Overview:
- Holds the current apple cell on the 16x16 snake game grid and answers "is the pixel/cell being drawn the apple?" for the display path.
- When the snake eats the apple (goodColl), it relocates the apple to the random candidate cell (randX, randY) supplied by an upstream LFSR.
- Candidates that land on any live snake body segment are rejected and retried.

Parameters:
- NUM_SEG, 50, number of body segment slots in the body port.
- INIT_X, 4'd10, apple X after reset or s_reset.
- INIT_Y, 4'd7, apple Y after reset or s_reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_reset  input  1  synchronous, active-high soft reset (new game); same effect as reset, applied at the clock edge.
- x  input  4  query cell column (current draw position).
- y  input  4  query cell row.
- randX  input  4  random candidate column.
- randY  input  4  random candidate row.
- goodColl  input  1  head has hit the apple; request relocation.
- body  input  NUM_SEG x 8 (packed [NUM_SEG-1:0][7:0])  snake segments; each byte is {X[7:4], Y[3:0]}; 8'h00 marks an unused slot.
- apple  output  1  registered; 1 when (x,y) equals the stored apple cell.

Behaviour:
- State:
  - appleX/appleY: 4-bit position registers.
  - pend: relocation-pending flag.
  - apple: output register.
- Reset (async reset, or sync s_reset at the edge): appleX=INIT_X, appleY=INIT_Y, pend=0, apple=0. reset has priority over s_reset; s_reset has priority over everything else.
- Occupied check (combinational): occ=1 if any slot i has body[i]!=8'h00 and body[i]=={randX,randY}. All NUM_SEG slots are compared in parallel; no length input.
- Candidate accepted when req=(goodColl | pend) and occ=0:
  - At that edge, appleX<=randX, appleY<=randY, pend<=0.
- Candidate rejected when req=1 and occ=1:
  - Position is held and pend<=1.
  - Retry happens every following cycle with the new randX/randY until a free cell is found.
- goodColl asserted while pend=1: no extra effect; still a single pending request.
- goodColl held high for several cycles: each accepted cycle reloads the position from the current rand inputs (last accepted value wins).
- Output register: apple<=(x==appleX && y==appleY), using the position register value before the edge. apple therefore reflects a relocation one clock after the position update, i.e. two edges after goodColl is sampled.
- No arithmetic; 4-bit equality compares only; no wrap-around concerns.
- Reset mid-relocation clears pend and restores INIT_X/INIT_Y.

Optional Feature:
- APPLE_BORDER_REJECT_EN
  - Defined: candidates with randX or randY equal to 0 or 15 (the wall ring) are treated as occupied (occ=1) and retried like a body hit.
  - Undefined: all 256 cells are legal apart from body cells.

Test Plan:
- Power-on: reset=1 for 2 cycles, x=1,y=1 -> apple=0; after release with x=10,y=7 -> apple=1 one cycle later.
- Relocate: body[0..3]=8'h48,47,46,45, others 0; randX=5,randY=8, x=5,y=8, goodColl=1 -> apple=0 after the 1st edge, apple=1 after the 2nd edge.
- Rejection: same body; randX=4,randY=8 (matches 8'h48), x=4,y=8, goodColl=1 for one cycle -> apple stays 0; pend=1; position stays 10,7.
- Retry: continuing the rejection case, next cycle randX=9,randY=2, goodColl=0, x=9,y=2 -> accepted via pend; apple=1 two edges after the change.
- Soft reset: after the apple is at 5,8, pulse s_reset for one cycle with x=10,y=7 -> apple=1 on the following cycle; x=5,y=8 -> apple=0.
- Feature: with APPLE_BORDER_REJECT_EN defined, randX=0,randY=3, goodColl=1 -> rejected, pend=1; without it -> apple relocates to 0,3.
